gate_vector_sequencer: RTL and testbench
========================================

Name: gate_vector_sequencer

Overview:
- Clocked stimulus/response stage for small combinational gate networks, e.g. an and_gate feeding a not_gate.
- Walks the input vector through every combination from 0 to 2^N_INPUTS-1 and holds each one for a settle window.
- Samples the gate's result bit at the end of each window and compares it with a parameterised truth table.
- Reports a pass/fail verdict, an error count and the first failing vector, replacing hand-written delay-and-assert sequences.

Parameters:
- N_INPUTS, 2, number of gate inputs driven; vector width.
- SETTLE_CYCLES, 1, extra cycles each vector is held before sampling (0 allowed).
- EXPECT_MASK, 4'b0111, expected truth table, width 2^N_INPUTS; bit i = expected dut_r for vec==i. The default is NAND.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; sampled at rising edge.
- vec  output  N_INPUTS  stimulus to the gate inputs (bit 0 = a, bit 1 = b).
- dut_r  input  1  gate result under test.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; sticky until next accepted start.
- pass  output  1  valid when done; 1 iff err_count==0.
- err_count  output  N_INPUTS+1  number of mismatching vectors in the current/last sweep.
- first_fail_vec  output  N_INPUTS  first mismatching vector; 0 if none.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; vec=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, settle counter=0.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at an edge: go to RUN. In the same edge: vec<=0, busy<=1, done<=0, pass<=0, err_count<=0, first_fail_vec<=0, settle counter<=SETTLE_CYCLES.
- start while busy is ignored.
- RUN:
  - Each vector is held for exactly SETTLE_CYCLES+1 cycles.
  - While the counter is nonzero, decrement it each edge.
  - At the edge where the counter is 0, sample dut_r and compare with EXPECT_MASK[vec].
  - A value of X or Z on dut_r counts as a mismatch.
  - On a mismatch, err_count increments. If this is the first mismatch, first_fail_vec<=vec.
- Same sampling edge, end of sweep: if vec==2^N_INPUTS-1, go to DONE. busy<=0, done<=1, pass<=(final err_count==0), where the final count includes the current comparison. vec holds its last value.
- Same sampling edge, otherwise: vec<=vec+1 and the counter reloads to SETTLE_CYCLES.
- Sweep length: (2^N_INPUTS)*(SETTLE_CYCLES+1) cycles from the accepting edge to the done edge. Default is 8 cycles.
- err_count cannot wrap; its maximum is 2^N_INPUTS, which fits in N_INPUTS+1 bits.
- DONE: all outputs hold. start=1 immediately restarts, same as from IDLE.
- Reset mid-sweep: aborts immediately to the reset values. No partial verdict is kept.

Optional Feature:
- STOP_ON_FAIL_EN defined:
  - The first mismatch ends the sweep at that sampling edge and goes to DONE with done=1, pass=0, err_count=1.
  - first_fail_vec = the failing vector; vec holds the failing vector.
- STOP_ON_FAIL_EN undefined: every vector is always checked, as above.

Test Plan:
- Reset: assert reset mid-cycle with no clock edge -> all outputs 0 immediately. Hold start=0 for 5 cycles -> still all 0, busy=0.
- Correct NAND model (dut_r = ~(vec[0]&vec[1])), defaults, 1-cycle start pulse:
  - vec sequence per cycle is 0,0,1,1,2,2,3,3.
  - done=1 on the 8th edge, with pass=1, err_count=0, first_fail_vec=0, busy=0.
- AND model instead of NAND (all four outputs inverted) -> done after 8 cycles, err_count=4, pass=0, first_fail_vec=0.
- dut_r stuck at 1 -> only vec=3 mismatches: err_count=1, first_fail_vec=3, pass=0. Pulse start again during busy -> ignored, run length is still 8 cycles.
- Reset asserted while vec=2 in RUN -> all outputs 0 immediately. A new start then gives a clean correct-NAND run: pass=1 after 8 cycles.
- With STOP_ON_FAIL_EN and dut_r stuck at 0 -> done after 2 cycles, err_count=1, first_fail_vec=0, vec=0, pass=0. Without the macro, the same stimulus gives err_count=3, first_fail_vec=0.

Source files
------------

// File: rtl/gate_vector_sequencer_if.sv
// gate_vector_sequencer_if
//   Bundles the sweep control, stimulus and verdict signals shared between
//   the sequencer and the gate network / controller around it.
//   master : the sequencer (drives vec and status, reads start and dut_r)
//   slave  : the environment (drives start and dut_r, reads vec and status)
//   Signals:
//     start          sweep request, sampled on the rising clock edge
//     vec            stimulus vector to the gate inputs (bit 0 = a, bit 1 = b)
//     dut_r          gate result under test
//     busy           sweep in progress
//     done           sweep finished; held until the next accepted start
//     pass           valid with done; 1 iff err_count == 0
//     err_count      mismatching vectors in the current or last sweep
//     first_fail_vec first mismatching vector, 0 if there was none
interface gate_vector_sequencer_if #(
  parameter int N_INPUTS = 2
);
  logic                start;
  logic [N_INPUTS-1:0] vec;
  logic                dut_r;
  logic                busy;
  logic                done;
  logic                pass;
  logic [N_INPUTS:0]   err_count;
  logic [N_INPUTS-1:0] first_fail_vec;

  modport master (
    input  start, dut_r,
    output vec, busy, done, pass, err_count, first_fail_vec
  );

  modport slave (
    output start, dut_r,
    input  vec, busy, done, pass, err_count, first_fail_vec
  );
endinterface

// File: rtl/gate_vector_sequencer.sv
// gate_vector_sequencer
//   Exhaustive stimulus/response stage for a small combinational gate network.
//   On start it walks vec from 0 to 2^N_INPUTS-1, holds each value for
//   SETTLE_CYCLES+1 cycles, samples dut_r on the last edge of the window and
//   compares it against bit vec of EXPECT_MASK. Reports pass/fail, the number
//   of mismatching vectors and the first failing vector.
//   Ports:
//     clk_i   rising-edge clock
//     reset_i asynchronous active-high reset
//     bus     gate_vector_sequencer_if.master (start, vec, dut_r, busy, done,
//             pass, err_count, first_fail_vec)
//   Build option:
//     STOP_ON_FAIL_EN  when defined, the first mismatch ends the sweep at that
//                      sampling edge with err_count=1 and vec left on the
//                      failing vector.
module gate_vector_sequencer #(
  parameter int                        N_INPUTS      = 2,
  parameter int                        SETTLE_CYCLES = 1,
  parameter logic [(2**N_INPUTS)-1:0]  EXPECT_MASK   = 4'b0111
) (
  input  logic clk_i,
  input  logic reset_i,
  gate_vector_sequencer_if.master bus
);

  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [N_INPUTS-1:0] vec_q, vec_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_INPUTS:0]   err_q, err_d;
  logic [N_INPUTS-1:0] ffv_q, ffv_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;

  logic              exp_bit;
  logic              mismatch;
  logic              last_vec;
  logic [N_INPUTS:0] err_inc;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ffv_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    exp_bit  = EXPECT_MASK[vec_q];
    // Case inequality so an X/Z result from the gate is a mismatch in sim.
    mismatch = (bus.dut_r !== exp_bit);
    last_vec = (vec_q == {N_INPUTS{1'b1}});
    // Count including the comparison made on this edge; cannot wrap since
    // at most 2^N_INPUTS vectors are checked.
    err_inc  = err_q + {{N_INPUTS{1'b0}}, mismatch};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          vec_d   = '0;
          cnt_d   = SETTLE_LD;
          err_d   = '0;
          ffv_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        // start is deliberately not looked at here.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          err_d = err_inc;
          if (mismatch && (err_q == '0)) ffv_d = vec_q;
`ifdef STOP_ON_FAIL_EN
          if (mismatch || last_vec) begin
`else
          if (last_vec) begin
`endif
            // vec keeps the value just checked.
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_inc == '0);
          end else begin
            vec_d = vec_q + 1'b1;
            cnt_d = SETTLE_LD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.vec            = vec_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_fail_vec = ffv_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
module tb_gate_vector_sequencer;

  localparam int N = 2;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   mode;  // 0 NAND, 1 AND, 2 stuck-1, 3 stuck-0

  gate_vector_sequencer_if #(.N_INPUTS(N)) bus ();

  gate_vector_sequencer u_dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus.master)
  );

  // Gate network model driven by the sequencer's stimulus.
  assign bus.dut_r = (mode == 0) ? ~(bus.vec[0] & bus.vec[1]) :
                     (mode == 1) ?  (bus.vec[0] & bus.vec[1]) :
                     (mode == 2) ? 1'b1 : 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] busy_e, input logic [3:0] done_e,
                          input logic [3:0] pass_e, input int err_e, input int ffv_e);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(busy_e));
    chk({tag, ".done"}, 32'(bus.done), 32'(done_e));
    chk({tag, ".pass"}, 32'(bus.pass), 32'(pass_e));
    chk({tag, ".err"},  32'(bus.err_count), 32'(err_e));
    chk({tag, ".ffv"},  32'(bus.first_fail_vec), 32'(ffv_e));
  endtask

  // Pulse start for one cycle, then count cycles (sampled on negedges) until
  // done. Optionally re-pulse start at cycle pulse_at while busy.
  task automatic run(input int pulse_at, input bit check_seq, input string tag, output int cycles);
    int exp_vec [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cycles = 0;
    while (!bus.done && cycles < 40) begin
      cycles++;
      if (check_seq && cycles <= 8)
        chk($sformatf("%s.vec%0d", tag, cycles), 32'(bus.vec), 32'(exp_vec[cycles-1]));
      if (cycles == pulse_at) bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    if (!bus.done) chk({tag, ".timeout"}, 32'(bus.done), 32'd1);
  endtask

  initial begin
    int cyc;
    total = 0;
    bad   = 0;
    mode  = 0;
    reset = 1'b0;
    bus.start = 1'b0;

    // Reset asserted between edges takes effect immediately.
    #2 reset = 1'b1;
    #1;
    chk_outs("rst_async", 0, 0, 0, 0, 0);
    chk("rst_async.vec", 32'(bus.vec), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk_outs("idle", 0, 0, 0, 0, 0);
    chk("idle.vec", 32'(bus.vec), 32'd0);

    // Correct NAND: full sequence, 8 cycles, pass.
    mode = 0;
    run(0, 1'b1, "nand", cyc);
    chk("nand.cycles", 32'(cyc), 32'd8);
    chk_outs("nand", 0, 1, 1, 0, 0);
    chk("nand.vec_hold", 32'(bus.vec), 32'd3);
    repeat (3) @(negedge clk);
    chk_outs("nand_hold", 0, 1, 1, 0, 0);

`ifdef STOP_ON_FAIL_EN
    // AND: first vector already fails.
    mode = 1;
    run(0, 1'b0, "and", cyc);
    chk("and.cycles", 32'(cyc), 32'd2);
    chk_outs("and", 0, 1, 0, 1, 0);
    chk("and.vec", 32'(bus.vec), 32'd0);

    // Stuck-1: only vec 3 fails, which is the last vector anyway.
    mode = 2;
    run(3, 1'b0, "st1", cyc);
    chk("st1.cycles", 32'(cyc), 32'd8);
    chk_outs("st1", 0, 1, 0, 1, 3);
    chk("st1.vec", 32'(bus.vec), 32'd3);
`else
    // AND: all four vectors mismatch.
    mode = 1;
    run(0, 1'b0, "and", cyc);
    chk("and.cycles", 32'(cyc), 32'd8);
    chk_outs("and", 0, 1, 0, 4, 0);

    // Stuck-1: only vec 3 mismatches; start re-pulse while busy is ignored.
    mode = 2;
    run(3, 1'b0, "st1", cyc);
    chk("st1.cycles", 32'(cyc), 32'd8);
    chk_outs("st1", 0, 1, 0, 1, 3);
    chk("st1.vec", 32'(bus.vec), 32'd3);
`endif

    // Reset in the middle of a sweep, while vec == 2.
    mode = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid.vec_before", 32'(bus.vec), 32'd2);
    chk("mid.busy_before", 32'(bus.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_outs("mid_rst", 0, 0, 0, 0, 0);
    chk("mid_rst.vec", 32'(bus.vec), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run(0, 1'b1, "clean", cyc);
    chk("clean.cycles", 32'(cyc), 32'd8);
    chk_outs("clean", 0, 1, 1, 0, 0);

    // Stuck-0: NAND expects 1 on vectors 0..2.
    mode = 3;
    run(0, 1'b0, "st0", cyc);
`ifdef STOP_ON_FAIL_EN
    chk("st0.cycles", 32'(cyc), 32'd2);
    chk_outs("st0", 0, 1, 0, 1, 0);
    chk("st0.vec", 32'(bus.vec), 32'd0);
`else
    chk("st0.cycles", 32'(cyc), 32'd8);
    chk_outs("st0", 0, 1, 0, 3, 0);
    chk("st0.vec", 32'(bus.vec), 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
